// File: rtl/qpsk_symbol_sequencer.sv
// QPSK symbol sequencer: buffers 2-bit symbols, walks a shared registered symbol ROM
// table by table, and emits a continuous sample stream with mid-scale idle fill.
module qpsk_symbol_sequencer #(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDLE_LEVEL = 141
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [1:0]        i_din,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  output logic [1:0]        o_rom_sel,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_rom_en,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_sample_out,
  output logic              o_sample_valid,
  output logic              o_sym_start,
  output logic              o_busy,
  output logic              o_underrun,
  input  logic              i_clr_underrun,
  output logic [15:0]       o_sym_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0]   FullCount = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr  = '1;
  localparam logic [DATA_W-1:0] IdleLevel = DATA_W'(IDLE_LEVEL);

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e            r_state, w_state_d;
  logic [1:0]        r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic [1:0]        r_cur_sym;
  logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_d;
  logic              r_rom_en, w_rom_en_d;
  logic              r_en_q1, r_start_q1;
  logic [DATA_W-1:0] r_sample_out;
  logic              r_sample_valid, r_sym_start;
  logic              r_underrun;
  logic [15:0]       r_sym_count;

  logic w_empty, w_full, w_push, w_pop, w_urun_set;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FullCount);
  // Full blocks the push even if a pop happens on the same edge.
  assign o_din_ready = !w_full && !i_rst;
  assign w_push      = i_din_valid && o_din_ready;

  always_comb begin
    w_state_d    = r_state;
    w_rom_addr_d = r_rom_addr;
    w_rom_en_d   = r_rom_en;
    w_pop        = 1'b0;
    w_urun_set   = 1'b0;
    case (r_state)
      StIdle: begin
        w_rom_en_d = 1'b0;
        if (i_enable && !w_empty) begin
          w_pop        = 1'b1;
          w_rom_addr_d = '0;
          w_rom_en_d   = 1'b1;
          w_state_d    = StPlay;
        end
      end
      StPlay: begin
        w_rom_en_d   = 1'b1;
        w_rom_addr_d = r_rom_addr + ADDR_W'(1);
        // Enable only matters on the last sample; a started symbol always completes.
        if (r_rom_addr == LastAddr) begin
          if (i_enable && !w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_rom_en_d = 1'b0;
            w_state_d  = StIdle;
            w_urun_set = i_enable;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_cur_sym      <= '0;
      r_rom_addr     <= '0;
      r_rom_en       <= 1'b0;
      r_en_q1        <= 1'b0;
      r_start_q1     <= 1'b0;
      r_sample_out   <= IdleLevel;
      r_sample_valid <= 1'b0;
      r_sym_start    <= 1'b0;
      r_underrun     <= 1'b0;
      r_sym_count    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_rom_addr <= w_rom_addr_d;
      r_rom_en   <= w_rom_en_d;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PtrW'(1);
        r_cur_sym   <= r_fifo[r_rd_ptr];
        r_sym_count <= r_sym_count + 16'd1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
      // One stage matches the ROM read latency, the next registers its data.
      r_en_q1        <= r_rom_en;
      r_start_q1     <= r_rom_en && (r_rom_addr == '0);
      r_sample_out   <= r_en_q1 ? i_rom_data : IdleLevel;
      r_sample_valid <= r_en_q1;
      r_sym_start    <= r_start_q1;
      if (w_urun_set) begin
        r_underrun <= 1'b1;
      end else if (i_clr_underrun) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign o_rom_sel      = r_cur_sym;
  assign o_rom_addr     = r_rom_addr;
  assign o_rom_en       = r_rom_en;
  assign o_sample_out   = r_sample_out;
  assign o_sample_valid = r_sample_valid;
  assign o_sym_start    = r_sym_start;
  assign o_busy         = (r_state == StPlay);
  assign o_underrun     = r_underrun;
  assign o_sym_count    = r_sym_count;

endmodule

// File: tb/tb_qpsk_symbol_sequencer.sv
// Directed bench for qpsk_symbol_sequencer with a registered four-table ROM model.
module tb_qpsk_symbol_sequencer;

  logic        clk = 1'b0;
  logic        i_rst, i_enable, i_din_valid, i_clr_underrun;
  logic [1:0]  i_din;
  logic        o_din_ready, o_rom_en, o_sample_valid, o_sym_start, o_busy, o_underrun;
  logic [1:0]  o_rom_sel;
  logic [3:0]  o_rom_addr;
  logic [8:0]  rom_data = '0;
  logic [8:0]  o_sample_out;
  logic [15:0] o_sym_count;

  int n_tests = 0;
  int n_fail  = 0;

  int t00 [16] = '{41, 10, 0, 10, 41, 87, 141, 195, 241, 272, 282, 272, 241, 195, 141, 87};
  int seq3 [5] = '{3, 1, 2, 0, 1};

  always #5 clk = ~clk;

  qpsk_symbol_sequencer dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_enable       (i_enable),
    .i_din          (i_din),
    .i_din_valid    (i_din_valid),
    .o_din_ready    (o_din_ready),
    .o_rom_sel      (o_rom_sel),
    .o_rom_addr     (o_rom_addr),
    .o_rom_en       (o_rom_en),
    .i_rom_data     (rom_data),
    .o_sample_out   (o_sample_out),
    .o_sample_valid (o_sample_valid),
    .o_sym_start    (o_sym_start),
    .o_busy         (o_busy),
    .o_underrun     (o_underrun),
    .i_clr_underrun (i_clr_underrun),
    .o_sym_count    (o_sym_count)
  );

  // Table 00 is the reference waveform; the others are inverted and/or quarter-rotated copies.
  function automatic int rom_val(input int sel, input int addr);
    int base;
    base = (sel >= 2) ? t00[(addr + 4) % 16] : t00[addr];
    return (sel % 2 == 1) ? 282 - base : base;
  endfunction

  always_ff @(posedge clk) begin
    if (o_rom_en) rom_data <= 9'(rom_val(int'(o_rom_sel), int'(o_rom_addr)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  task automatic push(input int sym);
    i_din       = 2'(sym);
    i_din_valid = 1'b1;
    step();
    i_din_valid = 1'b0;
  endtask

  task automatic wait_sym_start(input int budget);
    int n = 0;
    while (o_sym_start !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("sym_start_seen", o_sym_start, 1);
  endtask

  // Entered with sample 0 on the output; leaves with sample `last` on the output.
  task automatic check_symbol(input int sym, input int drop_at, input int last);
    for (int i = 0; i <= last; i++) begin
      if (i > 0) step();
      check($sformatf("sym%0d_sample%0d", sym, i), o_sample_out, rom_val(sym, i));
      check($sformatf("sym%0d_valid%0d", sym, i), o_sample_valid, 1);
      check($sformatf("sym%0d_start%0d", sym, i), o_sym_start, (i == 0));
      if (i == 0) check("rom_sel", o_rom_sel, sym);
      if (i == drop_at) i_enable = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_enable = 1'b0; i_din = '0; i_din_valid = 1'b0; i_clr_underrun = 1'b0;
    step();
    step();
    check("rst_busy", o_busy, 0);
    check("rst_sample", o_sample_out, 141);
    check("rst_valid", o_sample_valid, 0);
    check("rst_din_ready", o_din_ready, 0);
    check("rst_count", o_sym_count, 0);
    check("rst_underrun", o_underrun, 0);
    check("rst_rom_en", o_rom_en, 0);
    check("rst_sym_start", o_sym_start, 0);
    i_rst = 1'b0;
    #1;
    check("din_ready_after_rst", o_din_ready, 1);

    // Single symbol 00: exact pop timing and latency, then starve.
    i_enable = 1'b1;
    push(0);
    check("no_pop_on_push_edge", o_busy, 0);
    step();
    check("pop_busy", o_busy, 1);
    check("pop_rom_en", o_rom_en, 1);
    check("pop_rom_addr", o_rom_addr, 0);
    check("pop_count", o_sym_count, 1);
    step();
    check("latency_valid", o_sample_valid, 0);
    step();
    check_symbol(0, -1, 15);
    step();
    check("t1_idle_sample", o_sample_out, 141);
    check("t1_idle_valid", o_sample_valid, 0);
    check("t1_underrun", o_underrun, 1);
    check("t1_busy", o_busy, 0);

    // Four symbols back-to-back with no gap.
    do_reset();
    i_enable = 1'b1;
    for (int k = 0; k < 4; k++) push(k);
    wait_sym_start(10);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) step();
      check_symbol(s, -1, 15);
      if (s == 2) check("t2_no_early_underrun", o_underrun, 0);
    end
    step();
    check("t2_idle_valid", o_sample_valid, 0);
    check("t2_underrun", o_underrun, 1);
    check("t2_count", o_sym_count, 4);

    // Disabled fill: four accepted, fifth held until a pop frees a slot.
    i_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_din = 2'(seq3[k]);
      i_din_valid = 1'b1;
      check($sformatf("t3_ready%0d", k), o_din_ready, 1);
      step();
    end
    i_din = 2'(seq3[4]);
    check("t3_full_ready", o_din_ready, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      check("t3_held_busy", o_busy, 0);
      check("t3_held_sample", o_sample_out, 141);
      check("t3_held_ready", o_din_ready, 0);
    end
    i_enable = 1'b1;
    step();
    check("t3_pop_busy", o_busy, 1);
    check("t3_ready_after_pop", o_din_ready, 1);
    step();
    i_din_valid = 1'b0;
    wait_sym_start(10);
    for (int s = 0; s < 5; s++) begin
      if (s > 0) step();
      check_symbol(seq3[s], -1, 15);
    end
    step();
    check("t3_underrun", o_underrun, 1);

    // Lone clear pulse.
    i_clr_underrun = 1'b1;
    step();
    i_clr_underrun = 1'b0;
    check("clr_alone", o_underrun, 0);

    // Enable dropped mid-symbol with two queued.
    i_enable = 1'b0;
    push(0); push(1); push(2);
    i_enable = 1'b1;
    wait_sym_start(10);
    check_symbol(0, 5, 15);
    step();
    check("t4_idle_valid", o_sample_valid, 0);
    check("t4_busy", o_busy, 0);
    check("t4_underrun", o_underrun, 0);
    for (int j = 0; j < 3; j++) begin
      step();
      check("t4_stay_idle", o_busy, 0);
    end
    i_enable = 1'b1;
    wait_sym_start(10);
    check_symbol(1, -1, 15);
    step();
    check_symbol(2, -1, 15);
    step();
    check("t4_underrun_end", o_underrun, 1);

    // Reset mid-symbol with three queued.
    i_enable = 1'b0;
    push(3); push(2); push(1); push(0);
    i_enable = 1'b1;
    wait_sym_start(10);
    check_symbol(3, -1, 8);
    i_rst = 1'b1;
    #1;
    check("t5_ready_in_rst", o_din_ready, 0);
    step();
    check("t5_busy", o_busy, 0);
    check("t5_count", o_sym_count, 0);
    check("t5_underrun", o_underrun, 0);
    check("t5_rom_en", o_rom_en, 0);
    check("t5_valid", o_sample_valid, 0);
    i_rst = 1'b0;
    #1;
    check("t5_ready_after", o_din_ready, 1);
    for (int j = 0; j < 3; j++) begin
      step();
      check("t5_fifo_empty", o_busy, 0);
      check("t5_no_samples", o_sample_valid, 0);
    end

    // Clear colliding with a fresh starve event: set wins.
    push(2);
    wait_sym_start(10);
    check_symbol(2, -1, 15);
    step();
    check("t6_first_starve", o_underrun, 1);
    push(1);
    wait_sym_start(10);
    for (int j = 0; j < 13; j++) step();
    check("t6_last_addr", o_rom_addr, 15);
    i_clr_underrun = 1'b1;
    step();
    i_clr_underrun = 1'b0;
    check("t6_set_wins", o_underrun, 1);
    check("t6_idle", o_busy, 0);
    i_clr_underrun = 1'b1;
    step();
    i_clr_underrun = 1'b0;
    check("t6_clr_alone", o_underrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
